// File: rtl/seg_mux_driver.sv
// seg_mux_driver
// Time-multiplexed driver for a dual common-anode seven-segment display.
// Each DIP-switch nibble is shown as a hex digit on its own half of a
// shared segment bus. A blanking gap between the digits suppresses ghosting.
//
// Ports
//   clk    in   1  system clock, rising edge
//   reset  in   1  synchronous, active-low reset
//   s1     in   4  value for digit 0, already synchronized upstream
//   s2     in   4  value for digit 1, already synchronized upstream
//   seg    out  7  segment drive, active-low, {g,f,e,d,c,b,a}
//   an     out  2  anode enables, active-low; an[0] = digit 0, an[1] = digit 1
module seg_mux_driver #(
  parameter int HOLD_CYCLES  = 24000,
  parameter int BLANK_CYCLES = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int MAX_HB = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int MAXC   = (MAX_HB > 2) ? MAX_HB : 2;
  localparam int CW     = $clog2(MAXC);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  // The counter is loaded with N-1 on entry and the state expires when it
  // reads zero, so a state lasts exactly N cycles (N = 1 included).
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LD = HAS_BLANK ? CW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    digit_q, digit_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    digit_d = digit_q;
    seg_d   = seg_q;
    an_d    = an_q;

    if (cnt_q == '0) begin
      case (state_q)
        SHOW0:   state_d = HAS_BLANK ? BLANK0 : SHOW1;
        BLANK0:  state_d = SHOW1;
        SHOW1:   state_d = HAS_BLANK ? BLANK1 : SHOW0;
        default: state_d = SHOW0;
      endcase

      // The digit is captured only on SHOW entry and then frozen.
      case (state_d)
        SHOW0: begin
          cnt_d   = HOLD_LD;
          digit_d = s1;
          seg_d   = hex7(s1);
          an_d    = 2'b10;
        end
        SHOW1: begin
          cnt_d   = HOLD_LD;
          digit_d = s2;
          seg_d   = hex7(s2);
          an_d    = 2'b01;
        end
        default: begin
          cnt_d = BLANK_LD;
          seg_d = 7'b1111111;
          an_d  = 2'b11;
        end
      endcase
    end else if (state_q == SHOW0 || state_q == SHOW1) begin
      seg_d = hex7(digit_q);
    end
  end

  // Reset parks in BLANK1 with an expired counter, so the first released
  // edge goes straight to SHOW0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BLANK1;
      cnt_q   <= '0;
      seg_q   <= 7'b1111111;
      an_q    <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  always_ff @(posedge clk) begin
    digit_q <= digit_d;
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
module tb_seg_mux_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s1 = 4'h3;
  logic [3:0] s2 = 4'h5;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;

  always #5 clk = ~clk;

  seg_mux_driver #(.HOLD_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .reset(rst_n), .s1(s1), .s2(s2), .seg(seg_a), .an(an_a)
  );

  seg_mux_driver #(.HOLD_CYCLES(1), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .reset(rst_n), .s1(s1), .s2(s2), .seg(seg_b), .an(an_b)
  );

  int checks = 0;
  int passes = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];

  // Lit segments (active-high), {g,f,e,d,c,b,a}; the bus is the inverse.
  logic [6:0] lit_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] glyph(input logic [3:0] v);
    return ~lit_tab[v];
  endfunction

  // Reference model: position within the refresh period since reset release.
  int         t_m  [2] = '{-1, -1};
  logic [3:0] l0_m [2];
  logic [3:0] l1_m [2];

  task automatic model_step(input int c, input bit rn, input logic [3:0] a,
                            input logic [3:0] b, output logic [8:0] e);
    int h, bl, ph;
    h  = (c == 0) ? 4 : 1;
    bl = (c == 0) ? 2 : 0;
    if (!rn) begin
      t_m[c] = -1;
      e = {2'b11, 7'h7F};
    end else begin
      t_m[c] = t_m[c] + 1;
      ph = t_m[c] % (2 * (h + bl));
      if (ph == 0)      l0_m[c] = a;
      if (ph == h + bl) l1_m[c] = b;
      if (ph < h)               e = {2'b10, glyph(l0_m[c])};
      else if (ph < h + bl)     e = {2'b11, 7'h7F};
      else if (ph < 2 * h + bl) e = {2'b01, glyph(l1_m[c])};
      else                      e = {2'b11, 7'h7F};
    end
  endtask

  task automatic cyc(input bit rn, input logic [3:0] a, input logic [3:0] b);
    logic [8:0] ea, eb;
    @(negedge clk);
    #2;
    rst_n = rn;
    s1 = a;
    s2 = b;
    model_step(0, rn, a, b, ea);
    model_step(1, rn, a, b, eb);
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic compare(input string name, input logic [1:0] an_g, input logic [6:0] seg_g,
                         input logic [8:0] e);
    checks++;
    if ({an_g, seg_g} === e) passes++;
    else $display("FAIL %s at %0t: got an=%b seg=%b, expected an=%b seg=%b",
                  name, $time, an_g, seg_g, e[8:7], e[6:0]);
    checks++;
    if (an_g !== 2'b00) passes++;
    else $display("FAIL %s_an_both_on at %0t: got an=%b, expected not 00", name, $time, an_g);
  endtask

  // Monitor: outputs registered at the previous rising edge are sampled here.
  initial begin
    forever begin
      @(negedge clk);
      if (qa.size() > 0) compare("cfgA_h4b2", an_a, seg_a, qa.pop_front());
      if (qb.size() > 0) compare("cfgB_h1b0", an_b, seg_b, qb.pop_front());
    end
  end

  initial begin
    // 1: held reset, then release shows s1 = 3
    repeat (3) cyc(1'b0, 4'h3, 4'h5);
    repeat (6) cyc(1'b1, 4'h3, 4'h5);

    // 2: steady cycling over 5 periods
    cyc(1'b0, 4'h1, 4'hA);
    repeat (60) cyc(1'b1, 4'h1, 4'hA);

    // 3: s1 changes in the second cycle of SHOW0
    cyc(1'b0, 4'h0, 4'h0);
    cyc(1'b1, 4'h0, 4'h0);
    repeat (24) cyc(1'b1, 4'hF, 4'h0);

    // 4: full decode sweep, one value per period
    cyc(1'b0, 4'h0, 4'h0);
    for (int v = 0; v < 16; v++) begin
      repeat (12) cyc(1'b1, 4'(v), 4'(v));
    end

    // 5: single-cycle reset during SHOW1
    cyc(1'b0, 4'h6, 4'h9);
    repeat (7) cyc(1'b1, 4'h6, 4'h9);
    cyc(1'b0, 4'h6, 4'h9);
    repeat (20) cyc(1'b1, 4'hC, 4'hD);

    // Randomized inputs with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) != 0), 4'($urandom), 4'($urandom));
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && (qa.size() > 0 || qb.size() > 0); k++) @(negedge clk);
    #1;
    checks++;
    if (qa.size() == 0 && qb.size() == 0) passes++;
    else $display("FAIL drain: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
